// File: rtl/lspc_irq_timer.sv
// LSPC interrupt unit: vblank, programmable timer and power-on IRQ pending flags.
// Single-cycle: writes and line strobes act on the next CLK_6MB edge; no backpressure.
module lspc_irq_timer #(
    parameter int         TIMER_W = 32,
    parameter logic [8:0] VBL_POS = 9'h1F0
) (
    input  logic               CLK_6MB,
    input  logic               RESET,
    input  logic [15:0]        DATA,
    input  logic               WR_TIMERHIGH,
    input  logic               WR_TIMERLOW,
    input  logic               WR_MODE,
    input  logic               WR_IRQACK,
    input  logic [7:0]         LINE,
    input  logic               ACTIVE,
    input  logic               LINE_END,
    output logic               IRQ_VBL,
    output logic               IRQ_TIMER,
    output logic               IRQ_RESET,
    output logic [TIMER_W-1:0] TIMER_CNT
);

    logic [TIMER_W-1:0] reload;
    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] load_val;
    logic [3:0]         mode;
    logic               expired;
    logic               vbl_ev;
    logic               load_wr;
    logic               load;
    logic               run;
    logic               fire;

    assign vbl_ev  = LINE_END && ({ACTIVE, LINE} == VBL_POS);
    assign load_wr = WR_TIMERLOW && mode[1];
    assign load    = load_wr || (vbl_ev && mode[2]);
    assign run     = mode[0];
    // Zero-fire looks at the current count, so it still fires alongside a load.
    assign fire    = run && (cnt == '0) && !expired;

    // A low-word write that also loads must use the incoming word, not the stale register.
    always_comb begin
        load_val = reload;
        if (load_wr)
            load_val = {reload[TIMER_W-1:16], DATA};
    end

    always_ff @(posedge CLK_6MB or posedge RESET) begin
        if (RESET) begin
            reload <= '0;
            mode   <= '0;
        end else begin
            if (WR_TIMERHIGH)
                reload[TIMER_W-1:16] <= DATA;
            if (WR_TIMERLOW)
                reload[15:0] <= DATA;
            if (WR_MODE)
                mode <= DATA[7:4];
        end
    end

    always_ff @(posedge CLK_6MB or posedge RESET) begin
        if (RESET) begin
            cnt     <= '0;
            expired <= 1'b1;
        end else if (load) begin
            cnt     <= load_val;
            expired <= 1'b0;
        end else if (run) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (!expired) begin
                if (mode[3])
                    cnt <= reload;
                else
                    expired <= 1'b1;
            end
        end
    end

    // Sets take priority over a same-cycle acknowledge.
    always_ff @(posedge CLK_6MB or posedge RESET) begin
        if (RESET) begin
            IRQ_VBL   <= 1'b0;
            IRQ_TIMER <= 1'b0;
            IRQ_RESET <= 1'b1;
        end else begin
            if (vbl_ev)
                IRQ_VBL <= 1'b1;
            else if (WR_IRQACK && DATA[2])
                IRQ_VBL <= 1'b0;

            if (fire)
                IRQ_TIMER <= 1'b1;
            else if (WR_IRQACK && DATA[1])
                IRQ_TIMER <= 1'b0;

            if (WR_IRQACK && DATA[0])
                IRQ_RESET <= 1'b0;
        end
    end

    assign TIMER_CNT = cnt;

endmodule

// File: tb/tb_lspc_irq_timer.sv
// Directed-vector bench for lspc_irq_timer with hand-computed expectations.
module tb_lspc_irq_timer;

    logic        CLK_6MB;
    logic        RESET;
    logic [15:0] DATA;
    logic        WR_TIMERHIGH;
    logic        WR_TIMERLOW;
    logic        WR_MODE;
    logic        WR_IRQACK;
    logic [7:0]  LINE;
    logic        ACTIVE;
    logic        LINE_END;
    logic        IRQ_VBL;
    logic        IRQ_TIMER;
    logic        IRQ_RESET;
    logic [31:0] TIMER_CNT;

    int checks   = 0;
    int failures = 0;

    lspc_irq_timer dut (
        .CLK_6MB      (CLK_6MB),
        .RESET        (RESET),
        .DATA         (DATA),
        .WR_TIMERHIGH (WR_TIMERHIGH),
        .WR_TIMERLOW  (WR_TIMERLOW),
        .WR_MODE      (WR_MODE),
        .WR_IRQACK    (WR_IRQACK),
        .LINE         (LINE),
        .ACTIVE       (ACTIVE),
        .LINE_END     (LINE_END),
        .IRQ_VBL      (IRQ_VBL),
        .IRQ_TIMER    (IRQ_TIMER),
        .IRQ_RESET    (IRQ_RESET),
        .TIMER_CNT    (TIMER_CNT)
    );

    initial CLK_6MB = 1'b0;
    always #5 CLK_6MB = ~CLK_6MB;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic tick();
        @(posedge CLK_6MB);
        #1;
    endtask

    // sel: 0 TIMERHIGH, 1 TIMERLOW, 2 MODE, 3 IRQACK
    task automatic wr(input int sel, input logic [15:0] d);
        DATA         = d;
        WR_TIMERHIGH = (sel == 0);
        WR_TIMERLOW  = (sel == 1);
        WR_MODE      = (sel == 2);
        WR_IRQACK    = (sel == 3);
        tick();
        WR_TIMERHIGH = 1'b0;
        WR_TIMERLOW  = 1'b0;
        WR_MODE      = 1'b0;
        WR_IRQACK    = 1'b0;
        DATA         = 16'h0000;
    endtask

    initial begin
        int n;
        int irq_seen;
        int cnt_bad;
        int vbl_hi;
        logic do_ack;

        RESET = 1'b1;
        DATA = '0;
        WR_TIMERHIGH = 0; WR_TIMERLOW = 0; WR_MODE = 0; WR_IRQACK = 0;
        LINE = '0; ACTIVE = 0; LINE_END = 0;
        #12;
        check("rst_irq_reset", 32'(IRQ_RESET), 32'd1);
        check("rst_irq_vbl",   32'(IRQ_VBL),   32'd0);
        check("rst_irq_timer", 32'(IRQ_TIMER), 32'd0);
        check("rst_cnt",       TIMER_CNT,      32'd0);
        @(negedge CLK_6MB);
        RESET = 1'b0;
        tick();

        wr(3, 16'h0001);
        check("ack_reset", 32'(IRQ_RESET), 32'd0);

        // Auto-reload: period RELOAD+1
        wr(2, 16'h00B0);
        wr(0, 16'h0000);
        wr(1, 16'h0005);
        check("per_load_cnt", TIMER_CNT, 32'd5);
        check("per_load_irq", 32'(IRQ_TIMER), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("per_cnt_down", TIMER_CNT, 32'(5 - k));
            check("per_no_irq", 32'(IRQ_TIMER), 32'd0);
        end
        tick();
        check("per_fire_irq", 32'(IRQ_TIMER), 32'd1);
        check("per_fire_reload", TIMER_CNT, 32'd5);
        wr(3, 16'h0002);
        check("per_ack_irq", 32'(IRQ_TIMER), 32'd0);
        check("per_ack_cnt", TIMER_CNT, 32'd4);
        n = 0;
        while (!IRQ_TIMER && n < 20) begin
            tick();
            n++;
        end
        check("per_second_fire_dist", 32'(n), 32'd5);

        // One-shot
        wr(2, 16'h0000);
        wr(3, 16'h0002);
        check("os_pre_ack", 32'(IRQ_TIMER), 32'd0);
        wr(2, 16'h0030);
        wr(1, 16'h0003);
        check("os_load_cnt", TIMER_CNT, 32'd3);
        tick(); tick(); tick();
        check("os_zero_cnt", TIMER_CNT, 32'd0);
        check("os_zero_noirq", 32'(IRQ_TIMER), 32'd0);
        tick();
        check("os_fire_irq", 32'(IRQ_TIMER), 32'd1);
        check("os_fire_cnt", TIMER_CNT, 32'd0);
        wr(3, 16'h0002);
        check("os_ack", 32'(IRQ_TIMER), 32'd0);
        irq_seen = 0;
        cnt_bad  = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (IRQ_TIMER) irq_seen++;
            if (TIMER_CNT != 32'd0) cnt_bad++;
        end
        check("os_idle_irqs", 32'(irq_seen), 32'd0);
        check("os_idle_cnt_nonzero", 32'(cnt_bad), 32'd0);

        // Fire and ack in the same cycle: fire wins
        wr(1, 16'h0002);
        tick(); tick();
        check("same_pre_cnt", TIMER_CNT, 32'd0);
        wr(3, 16'h0002);
        check("same_ack_irq", 32'(IRQ_TIMER), 32'd1);
        wr(3, 16'h0002);
        check("same_ack2_irq", 32'(IRQ_TIMER), 32'd0);

        // Fire and load in the same cycle
        wr(1, 16'h0002);
        tick(); tick();
        wr(1, 16'h0007);
        check("fl_irq", 32'(IRQ_TIMER), 32'd1);
        check("fl_cnt", TIMER_CNT, 32'd7);

        // Vblank over two compressed frames (4 pixels per line)
        wr(2, 16'h0050);
        wr(0, 16'h0001);
        wr(1, 16'h2345);
        vbl_hi = 0;
        do_ack = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int pos = 9'h0F8; pos <= 9'h1FF; pos++) begin
                for (int pix = 0; pix < 4; pix++) begin
                    {ACTIVE, LINE} = 9'(pos);
                    LINE_END  = (pix == 3);
                    WR_IRQACK = do_ack;
                    DATA      = do_ack ? 16'h0004 : 16'h0000;
                    tick();
                    if (IRQ_VBL) vbl_hi++;
                    if (do_ack) check("vbl_ack", 32'(IRQ_VBL), 32'd0);
                    do_ack = 1'b0;
                    if (pos == 9'h1F0 && pix == 3) begin
                        check("vbl_set", 32'(IRQ_VBL), 32'd1);
                        check("vbl_reload_cnt", TIMER_CNT, 32'h0001_2345);
                        do_ack = 1'b1;
                    end
                end
            end
        end
        WR_IRQACK = 1'b0; DATA = '0; LINE_END = 1'b0;
        {ACTIVE, LINE} = 9'h000;
        check("vbl_high_cycles", 32'(vbl_hi), 32'd2);

        // Async reset with count loaded and IRQs pending
        wr(0, 16'h0000);
        wr(2, 16'h0030);
        wr(1, 16'h0000);
        tick();
        check("ar_timer_pend", 32'(IRQ_TIMER), 32'd1);
        wr(2, 16'h0020);
        wr(1, 16'd1234);
        {ACTIVE, LINE} = 9'h1F0;
        LINE_END = 1'b1;
        tick();
        LINE_END = 1'b0;
        {ACTIVE, LINE} = 9'h000;
        check("ar_cnt_1234", TIMER_CNT, 32'd1234);
        check("ar_vbl_pend", 32'(IRQ_VBL), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("ar_irq_reset", 32'(IRQ_RESET), 32'd1);
        check("ar_irq_vbl",   32'(IRQ_VBL),   32'd0);
        check("ar_irq_timer", 32'(IRQ_TIMER), 32'd0);
        check("ar_cnt",       TIMER_CNT,      32'd0);
        @(negedge CLK_6MB);
        RESET = 1'b0;
        wr(2, 16'h0010);
        tick(); tick();
        check("ar_expired_noirq", 32'(IRQ_TIMER), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
